// File: rtl/counter_cmd_sequencer.sv
// ============================================================================
// Module   : counter_cmd_sequencer
// Purpose  : Valid/ready command sequencer driving a loadable up/down counter
//            (d, load, up_down, active-low clear). Commands: LOAD value,
//            count UP n, count DOWN n, HOLD n. A shadow copy of the counter
//            value is kept so the expected count is available every cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_cmd_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [DATA_WIDTH-1:0] d,
    output logic                  load,
    output logic                  up_down,
    output logic                  cnt_clear_n,
    output logic [DATA_WIDTH-1:0] shadow_q,
    output logic                  busy,
    output logic                  done
);

    // ------------------------------------------------------------------
    // Opcodes and state encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

    // ------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------
    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [1:0]            op_lat;
    logic [DATA_WIDTH-1:0] data_lat;
    logic [DATA_WIDTH-1:0] shadow_next;
    logic [LEN_WIDTH-1:0]  accept_len;
    logic                  accept;
    logic                  last_cycle;

    // A command is taken only from IDLE; cmd_* is not looked at otherwise.
    assign accept = (state == S_IDLE) && cmd_valid;

    // LOAD always takes one cycle; a zero length means a single cycle too.
    assign accept_len = ((cmd_op == OP_LOAD) || (cmd_len == '0)) ? LEN_ONE : cmd_len;

    // remaining is never 0 in RUN; treating 0 as last keeps a corrupted
    // count from wrapping into a 2^LEN_WIDTH-cycle run.
    assign last_cycle = (remaining <= LEN_ONE);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= S_INIT;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_INIT:  next_state = S_IDLE;
            S_IDLE:  next_state = accept ? S_RUN : S_IDLE;
            S_RUN:   next_state = last_cycle ? S_IDLE : S_RUN;
            default: next_state = S_INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow value after one RUN edge of the latched command; this is
    // exactly what the counter computes from the outputs driven below.
    // ------------------------------------------------------------------
    always_comb begin
        shadow_next = shadow_q;
        case (op_lat)
            OP_LOAD: shadow_next = data_lat;
            OP_UP:   shadow_next = shadow_q + DATA_ONE;
            OP_DOWN: shadow_next = shadow_q - DATA_ONE;
            OP_HOLD: shadow_next = shadow_q;
            default: shadow_next = shadow_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: command latch, cycle counter, shadow, done pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            shadow_q  <= '0;
            remaining <= '0;
            op_lat    <= OP_LOAD;
            data_lat  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_lat    <= cmd_op;
                        data_lat  <= cmd_data;
                        remaining <= accept_len;
                    end
                end
                S_RUN: begin
                    shadow_q  <= shadow_next;
                    remaining <= remaining - LEN_ONE;
                    if (last_cycle) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    // INIT: the counter is being zeroed, shadow already 0.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode from registered state and latched command
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        cnt_clear_n = 1'b1;
        load        = 1'b1;
        d           = shadow_q;
        up_down     = 1'b0;
        case (state)
            S_INIT: begin
                cnt_clear_n = 1'b0;
                load        = 1'b0;
                d           = '0;
            end
            S_IDLE: begin
                // Reload the counter with its own value so it cannot drift.
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_RUN: begin
                case (op_lat)
                    OP_LOAD: begin
                        load = 1'b1;
                        d    = data_lat;
                    end
                    OP_UP: begin
                        load    = 1'b0;
                        up_down = 1'b1;
                    end
                    OP_DOWN: begin
                        load    = 1'b0;
                        up_down = 1'b0;
                    end
                    default: begin
                        // HOLD: self-reload, same as IDLE.
                        load = 1'b1;
                    end
                endcase
            end
            default: begin
                cnt_clear_n = 1'b0;
                load        = 1'b0;
                d           = '0;
            end
        endcase
    end

endmodule

`default_nettype wire
